// File: rtl/fifo_arbiter_if.sv
// Handshake bundle between the fifo_arbiter, its two writers, its reader and the shared FIFO.
// DEPTH must match the fifo_arbiter instance so that level has the same width on both sides.
interface fifo_arbiter_if #(
  parameter int DEPTH = 4096
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             a_valid;
  logic [15:0]      a_data;
  logic             a_ready;
  logic             b_valid;
  logic [15:0]      b_data;
  logic             b_ready;
  logic             rd_req;
  logic             rd_ready;
  logic             rd_valid;
  logic [15:0]      rd_data;
  logic             fifo_en;
  logic             fifo_rst;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [15:0]      fifo_din;
  logic [15:0]      fifo_dout;
  logic [CNT_W-1:0] level;

  modport master (
    output flush, a_valid, a_data, b_valid, b_data, rd_req, fifo_dout,
    input  a_ready, b_ready, rd_ready, rd_valid, rd_data,
           fifo_en, fifo_rst, fifo_wr, fifo_rd, fifo_din, level
  );

  modport slave (
    input  flush, a_valid, a_data, b_valid, b_data, rd_req, fifo_dout,
    output a_ready, b_ready, rd_ready, rd_valid, rd_data,
           fifo_en, fifo_rst, fifo_wr, fifo_rd, fifo_din, level
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Arbitrates writers A/B and one reader onto the shared FIFO's single-op port, tracks occupancy, sequences flushes.
// Optional FIFO_ARB_STATS_EN adds saturating transfer/stall counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | first cycle out of reset, no grants
// ST_FLUSH | FIFO pointer clear (fifo_en=fifo_rst=1), no grants
// ST_RUN   | one read or write per cycle, or idle
module fifo_arbiter #(
  parameter int DEPTH        = 4096,
  parameter int MAX_RD_BURST = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0] stat_wr_a,
  output logic [15:0] stat_wr_b,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_stall,
`endif
  fifo_arbiter_if.slave bus
);
  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_L   = CNT_W'(DEPTH);
  localparam logic [7:0]        BURST_MAX = 8'(MAX_RD_BURST);

  typedef enum logic [1:0] {ST_INIT, ST_FLUSH, ST_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] level_q;
  logic             rr_b;
  logic [7:0]       rd_burst;
  logic             rd_valid_q;

  logic any_valid;
  logic writer_ok;
  logic run_op;
  logic do_rd;
  logic do_wr;
  logic grant_a;
  logic grant_b;
  logic flush_now;

  // A read yields to a waiting writer only once the burst allowance is used up.
  always_comb begin
    any_valid = bus.a_valid | bus.b_valid;
    writer_ok = any_valid && (level_q < DEPTH_L);
    run_op    = (state == ST_RUN) && !bus.flush;
    do_rd     = run_op && bus.rd_req && (level_q != '0) &&
                !((rd_burst == BURST_MAX) && writer_ok);
    do_wr     = run_op && !do_rd && writer_ok;
    grant_b   = do_wr && (rr_b ? bus.b_valid : !bus.a_valid);
    grant_a   = do_wr && !grant_b;
    flush_now = (state == ST_FLUSH) || ((state == ST_RUN) && bus.flush);
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.rd_ready = do_rd;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.fifo_dout;
  assign bus.fifo_en  = (state == ST_FLUSH) || do_rd || do_wr;
  assign bus.fifo_rst = (state == ST_FLUSH);
  assign bus.fifo_wr  = do_wr;
  assign bus.fifo_rd  = do_rd;
  assign bus.fifo_din = grant_b ? bus.b_data : bus.a_data;
  assign bus.level    = level_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_INIT;
      level_q    <= '0;
      rr_b       <= 1'b0;
      rd_burst   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      unique case (state)
        ST_INIT:  state <= ST_FLUSH;
        ST_FLUSH: state <= bus.flush ? ST_FLUSH : ST_RUN;
        ST_RUN:   if (bus.flush) state <= ST_FLUSH;
        default:  state <= ST_INIT;
      endcase
      // Occupancy is cleared on entry to FLUSH so the flush cycle already reports empty.
      if (flush_now) begin
        level_q  <= '0;
        rr_b     <= 1'b0;
        rd_burst <= '0;
      end else if (do_wr) begin
        level_q  <= level_q + 1'b1;
        rr_b     <= grant_a;
        rd_burst <= '0;
      end else if (do_rd) begin
        level_q <= level_q - 1'b1;
        if (!any_valid)
          rd_burst <= '0;
        else if (rd_burst != BURST_MAX)
          rd_burst <= rd_burst + 1'b1;
      end else if (!any_valid) begin
        rd_burst <= '0;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_wr_a  <= '0;
      stat_wr_b  <= '0;
      stat_rd    <= '0;
      stat_stall <= '0;
    end else if (flush_now) begin
      stat_wr_a  <= '0;
      stat_wr_b  <= '0;
      stat_rd    <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_a) stat_wr_a <= sat_inc(stat_wr_a);
      if (grant_b) stat_wr_b <= sat_inc(stat_wr_b);
      if (do_rd)   stat_rd   <= sat_inc(stat_rd);
      if ((state == ST_RUN) && any_valid && !do_wr)
        stat_stall <= sat_inc(stat_stall);
    end
  end
`endif
endmodule
